three_bit_full_adder: RTL and testbench

//   Registered ripple-carry adder: sum = a + b + c_in over WIDTH bits (default 3), with carry-out.

---
 rtl/three_bit_full_adder_if.sv | 31 +++
 rtl/three_bit_full_adder.sv | 62 ++++++
 tb/tb_three_bit_full_adder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/three_bit_full_adder_if.sv
//------------------------------------------------------------------------------
// Module      : three_bit_full_adder_if
// Description : Operand/result bundle for the registered ripple-carry adder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface three_bit_full_adder_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             out_valid;

    modport master (
        output in_valid, a, b, c_in,
        input  sum, c_out, overflow, out_valid
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output sum, c_out, overflow, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/three_bit_full_adder.sv
//------------------------------------------------------------------------------
// Module      : three_bit_full_adder
// Description : Ripple-carry adder built from 1-bit full-adder cells, registered.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module three_bit_full_adder #(
    parameter int WIDTH = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    three_bit_full_adder_if.slave bus
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_overflow;

    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_out_valid;

    assign w_carry[0] = bus.c_in;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            assign w_sum[i]       = bus.a[i] ^ bus.b[i] ^ w_carry[i];
            assign w_carry[i+1]   = (bus.a[i] & bus.b[i]) |
                                    (w_carry[i] & (bus.a[i] ^ bus.b[i]));
        end
    endgenerate

    // Signed overflow: carries into and out of the MSB disagree.
    assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    // Operands are only sampled under in_valid, so idle X never reaches the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum      <= w_sum;
                r_c_out    <= w_carry[WIDTH];
                r_overflow <= w_overflow;
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
    assign bus.overflow  = r_overflow;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_three_bit_full_adder.sv
//------------------------------------------------------------------------------
// Module      : tb_three_bit_full_adder
// Description : Directed table, exhaustive sweeps and random stimulus vs model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_three_bit_full_adder;

    localparam int W = 3;

    logic clk;
    logic rst_n;

    three_bit_full_adder_if #(.WIDTH(W)) bus ();

    three_bit_full_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         vld;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         ovalid;
    } vec_t;

    int vectors;
    int miscompares;

    // Behavioural reference: integer arithmetic on the sampled operands.
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;
    logic         m_valid;

    task automatic model_edge(input logic r, input logic v, input int a, input int b, input int cin);
        int total, sa, sb, s;
        if (!r) begin
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
        end else if (v) begin
            total   = a + b + cin;
            m_sum   = W'(total % (1 << W));
            m_cout  = (total >= (1 << W));
            sa      = (a >= (1 << (W-1))) ? a - (1 << W) : a;
            sb      = (b >= (1 << (W-1))) ? b - (1 << W) : b;
            s       = sa + sb + cin;
            m_ovf   = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive_edge(input logic r, input logic v, input int a, input int b, input int cin);
        rst_n        = r;
        bus.in_valid = v;
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.c_in     = cin[0];
        @(posedge clk);
        model_edge(r, v, a, b, cin);
        #1;
    endtask

    task automatic compare(input string name, input logic [W-1:0] es, input logic ec,
                           input logic eo, input logic ev);
        vectors++;
        if (bus.sum !== es || bus.c_out !== ec || bus.overflow !== eo || bus.out_valid !== ev) begin
            miscompares++;
            $display("FAIL %s: got sum=%0d c_out=%0b ovf=%0b out_valid=%0b, want sum=%0d c_out=%0b ovf=%0b out_valid=%0b",
                     name, bus.sum, bus.c_out, bus.overflow, bus.out_valid, es, ec, eo, ev);
        end
    endtask

    vec_t tbl [14];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c_in     = 1'b0;
        m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;

        //        rst  vld  a  b  cin  sum cout ovf ovalid
        tbl[0]  = '{1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 3'd3, 3'd1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 3'd7, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 3'd2, 3'd3, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 3'd6, 3'd3, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 14; i++) begin
            drive_edge(tbl[i].rst_n, tbl[i].vld, int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].cin));
            compare($sformatf("table[%0d]", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].ovalid);
        end

        // Exhaustive back-to-back sweep for both carry-in values.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 64; i++) begin
                drive_edge(1'b1, 1'b1, i % 8, i / 8, c);
                compare($sformatf("exh c_in=%0d a=%0d b=%0d", c, i % 8, i / 8),
                        m_sum, m_cout, m_ovf, m_valid);
            end
        end

        // Random mix of reset, idle and valid cycles.
        for (int i = 0; i < 300; i++) begin
            drive_edge(($urandom_range(15) != 0), ($urandom_range(3) != 0),
                       int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(1)));
            compare($sformatf("rand[%0d]", i), m_sum, m_cout, m_ovf, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
